// File: rtl/sindoku_input_conditioner.sv
// SINdoku input conditioner: button sync/debounce/auto-repeat into one-cycle
// pulses, plus a synchronised, range-checked switch value.
//
// Ports:
//   Clk, Reset (async, active-high)
//   Btn*_raw      : raw bouncy buttons (R, L, U, D, C, Check, Ack)
//   Sw[4:0]       : raw entry switches
//   R/L/U/D/C     : one-cycle move/enter pulses, at most one per cycle
//   CheckSolu/Ack : independent one-cycle pulses
//   userIn[4:0]   : last switch value in 0..9
//   userIn_valid  : synchronised switch value is 0..9

// Per-button conditioner: 2-flop sync, debounce FSM, optional auto-repeat.
// Ports: Clk, Reset, i_raw (async button), o_pulse (one-cycle, unregistered).
module sindoku_btn_fsm #(
    parameter int DB_CYCLES    = 500000,
    parameter int REPEAT_DELAY = 50000000,
    parameter int REPEAT_RATE  = 15000000,
    parameter int CNT_W        = 26,
    parameter bit REPEAT       = 1'b1
) (
    input  logic Clk,
    input  logic Reset,
    input  logic i_raw,
    output logic o_pulse
);
    typedef enum logic [2:0] {
        S_IDLE, S_WQ, S_PRESS, S_HOLD, S_RPT, S_WR
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic             r_first, w_first_nxt;
    logic             r_s1, r_s2;

    // Counter saturates rather than wrapping (e.g. a long hold on C).
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_first <= 1'b0;
        end else begin
            r_s1    <= i_raw;
            r_s2    <= r_s1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_first <= w_first_nxt;
        end
    end

    // The pulse cycle itself counts toward the repeat interval, so HOLD is
    // entered with cnt=1: pulse-to-pulse spacing equals the parameter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_first_nxt = r_first;
        o_pulse     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_s2) begin
                    w_state_nxt = S_WQ;
                    w_cnt_nxt   = '0;
                end
            end
            S_WQ: begin
                if (!r_s2)                 w_state_nxt = S_IDLE;
                else if (r_cnt == DB_LAST) w_state_nxt = S_PRESS;
                else                       w_cnt_nxt   = w_cnt_inc;
            end
            S_PRESS: begin
                o_pulse     = 1'b1;
                w_state_nxt = S_HOLD;
                w_cnt_nxt   = CNT_ONE;
                w_first_nxt = 1'b1;
            end
            S_HOLD: begin
                if (!r_s2) begin
                    w_state_nxt = S_WR;
                    w_cnt_nxt   = '0;
                end else if (REPEAT &&
                             r_cnt == (r_first ? RD_LAST : RR_LAST)) begin
                    w_state_nxt = S_RPT;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_RPT: begin
                o_pulse     = 1'b1;
                w_state_nxt = S_HOLD;
                w_cnt_nxt   = CNT_ONE;
                w_first_nxt = 1'b0;
            end
            S_WR: begin
                if (r_s2) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end
endmodule

module sindoku_input_conditioner #(
    parameter int DB_CYCLES    = 500000,
    parameter int REPEAT_DELAY = 50000000,
    parameter int REPEAT_RATE  = 15000000,
    parameter int CNT_W        = 26
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       BtnR_raw,
    input  logic       BtnL_raw,
    input  logic       BtnU_raw,
    input  logic       BtnD_raw,
    input  logic       BtnC_raw,
    input  logic       BtnCheck_raw,
    input  logic       BtnAck_raw,
    input  logic [4:0] Sw,
    output logic       R,
    output logic       L,
    output logic       U,
    output logic       D,
    output logic       C,
    output logic       CheckSolu,
    output logic       Ack,
    output logic [4:0] userIn,
    output logic       userIn_valid
);
    logic [6:0] w_raw, w_pulse;
    logic [4:0] r_sw_s1, r_sw_s2;
    logic       w_sw_ok;
    logic       w_r, w_l, w_u, w_d, w_c;

    // Index 0..3 are the repeating move buttons.
    assign w_raw = {BtnAck_raw, BtnCheck_raw, BtnC_raw,
                    BtnD_raw, BtnU_raw, BtnL_raw, BtnR_raw};

    for (genvar gi = 0; gi < 7; gi++) begin : g_btn
        sindoku_btn_fsm #(
            .DB_CYCLES   (DB_CYCLES),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE),
            .CNT_W       (CNT_W),
            .REPEAT      (gi < 4)
        ) u_btn (
            .Clk    (Clk),
            .Reset  (Reset),
            .i_raw  (w_raw[gi]),
            .o_pulse(w_pulse[gi])
        );
    end

    assign w_sw_ok = (r_sw_s2 <= 5'd9);

    // Losers of the move-group priority are dropped, never deferred.
    assign w_r = w_pulse[0];
    assign w_l = w_pulse[1] & ~w_pulse[0];
    assign w_u = w_pulse[2] & ~|w_pulse[1:0];
    assign w_d = w_pulse[3] & ~|w_pulse[2:0];
    assign w_c = w_pulse[4] & ~|w_pulse[3:0] & userIn_valid;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_sw_s1      <= '0;
            r_sw_s2      <= '0;
            userIn       <= '0;
            userIn_valid <= 1'b0;
            R            <= 1'b0;
            L            <= 1'b0;
            U            <= 1'b0;
            D            <= 1'b0;
            C            <= 1'b0;
            CheckSolu    <= 1'b0;
            Ack          <= 1'b0;
        end else begin
            r_sw_s1      <= Sw;
            r_sw_s2      <= r_sw_s1;
            userIn_valid <= w_sw_ok;
            if (w_sw_ok) userIn <= r_sw_s2;
            R            <= w_r;
            L            <= w_l;
            U            <= w_u;
            D            <= w_d;
            C            <= w_c;
            CheckSolu    <= w_pulse[5];
            Ack          <= w_pulse[6];
        end
    end
endmodule
